// File: rtl/ascon_decrypt_fsm.sv
// ASCON-128 decryption sequencer: init, one AD block, N_BLOCKS ciphertext blocks, tag check.
// Define ASCON_DEC_RELEASE_GATE_EN to withhold plaintext until the tag has been verified.
module ascon_decrypt_fsm #(
    parameter int unsigned N_BLOCKS = 23,
    parameter int unsigned CNT_W    = $clog2(N_BLOCKS)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [N_BLOCKS*64-1:0] cipher_i,
    input  logic [127:0]          tag_i,
    input  logic [63:0]           da_i,
    output logic [N_BLOCKS*64-1:0] plain_o,
    output logic                  tag_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  core_init_o,
    output logic                  core_associate_data_o,
    output logic                  core_finalisation_o,
    output logic                  core_decrypt_o,
    output logic [63:0]           core_data_o,
    output logic                  core_data_valid_o,
    input  logic                  core_end_initialisation_i,
    input  logic                  core_end_associate_i,
    input  logic                  core_out_valid_i,
    input  logic [63:0]           core_out_i,
    input  logic [127:0]          core_tag_i,
    input  logic                  core_end_tag_i
);

    localparam int unsigned W = N_BLOCKS * 64;
    localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(N_BLOCKS - 2);
    localparam logic [CNT_W-1:0] LAST_BLK_IDX  = CNT_W'(N_BLOCKS - 1);

    typedef enum logic [2:0] {StIdle, StInit, StAd, StData, StFinal, StCheck} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q;
    logic [127:0]     tag_q;
    logic             tag_got_q, last_got_q, tag_valid_q;
    logic [W-1:0]     plain_q;
    logic             wr_en, tag_match, fin_done, start_accept;
    logic [CNT_W-1:0] wr_idx;

    assign start_accept = (state_q == StIdle) && start_i;
    assign tag_match    = ~|(tag_q ^ tag_i);
    // FINAL waits for both the last block and the tag, whichever order they arrive in.
    assign fin_done     = (last_got_q | core_out_valid_i) & (tag_got_q | core_end_tag_i);
    assign wr_en        = core_out_valid_i && (state_q == StData || state_q == StFinal);
    assign wr_idx       = (state_q == StFinal) ? LAST_BLK_IDX : idx_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d               = state_q;
        busy_o                = 1'b1;
        done_o                = 1'b0;
        core_init_o           = 1'b0;
        core_associate_data_o = 1'b0;
        core_finalisation_o   = 1'b0;
        core_decrypt_o        = 1'b0;
        core_data_valid_o     = 1'b0;
        core_data_o           = '0;
        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
                if (start_i) state_d = StInit;
            end
            StInit: begin
                core_init_o = 1'b1;
                if (core_end_initialisation_i) state_d = StAd;
            end
            StAd: begin
                core_associate_data_o = 1'b1;
                core_data_valid_o     = 1'b1;
                core_data_o           = da_i;
                if (core_end_associate_i) state_d = StData;
            end
            StData: begin
                core_decrypt_o    = 1'b1;
                core_data_valid_o = 1'b1;
                core_data_o       = cipher_i[64*int'(idx_q) +: 64];
                if (core_out_valid_i && idx_q == LAST_DATA_IDX) state_d = StFinal;
            end
            StFinal: begin
                core_finalisation_o = 1'b1;
                core_decrypt_o      = 1'b1;
                core_data_valid_o   = 1'b1;
                core_data_o         = cipher_i[W-64 +: 64];
                if (fin_done) state_d = StCheck;
            end
            StCheck: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q       <= '0;
            tag_q       <= '0;
            tag_got_q   <= 1'b0;
            last_got_q  <= 1'b0;
            tag_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: if (start_i) begin
                    idx_q       <= '0;
                    tag_got_q   <= 1'b0;
                    last_got_q  <= 1'b0;
                    tag_valid_q <= 1'b0;
                end
                StAd: if (core_end_associate_i) idx_q <= '0;
                StData: if (core_out_valid_i && idx_q != LAST_DATA_IDX) idx_q <= idx_q + CNT_W'(1);
                StFinal: begin
                    if (core_out_valid_i) last_got_q <= 1'b1;
                    if (core_end_tag_i) begin
                        tag_q     <= core_tag_i;
                        tag_got_q <= 1'b1;
                    end
                end
                StCheck: tag_valid_q <= tag_match;
                default: ;
            endcase
        end
    end

`ifdef ASCON_DEC_RELEASE_GATE_EN
    logic [W-1:0] buf_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            buf_q   <= '0;
            plain_q <= '0;
        end else begin
            if (start_accept) plain_q <= '0;
            if (wr_en) buf_q[64*int'(wr_idx) +: 64] <= core_out_i;
            if (state_q == StCheck) begin
                if (tag_match) plain_q <= buf_q;
                else           buf_q   <= '0;
            end
        end
    end
`else
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)    plain_q <= '0;
        else if (wr_en) plain_q[64*int'(wr_idx) +: 64] <= core_out_i;
    end
`endif

    assign plain_o     = plain_q;
    assign tag_valid_o = tag_valid_q;

endmodule

// File: tb/tb_ascon_decrypt_fsm.sv
// Directed bench for ascon_decrypt_fsm with a behavioural core that XORs data with a constant.
module tb_ascon_decrypt_fsm;
    localparam int unsigned N = 23;
    localparam int unsigned W = N * 64;
    localparam logic [63:0]  XMASK = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [127:0] MTAG  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic           clock_i = 1'b0, reset_i = 1'b1, start_i = 1'b0;
    logic [W-1:0]   cipher_i, plain_o, exp_plain;
    logic [127:0]   tag_i;
    logic [63:0]    da_i = 64'h0BAD_CAFE_1234_5678;
    logic           tag_valid_o, busy_o, done_o;
    logic           core_init_o, core_associate_data_o, core_finalisation_o, core_decrypt_o;
    logic [63:0]    core_data_o, core_out_i;
    logic           core_data_valid_o;
    logic           core_end_initialisation_i, core_end_associate_i, core_out_valid_i;
    logic           core_end_tag_i;
    logic [127:0]   core_tag_i;

    int nchecks = 0, nerr = 0, cyc = 0;
    int stall = 0, ov_dly = 0, tag_dly = 0, cnt = 0;
    bit seen;
    int extra;

    ascon_decrypt_fsm #(.N_BLOCKS(N)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
        .cipher_i(cipher_i), .tag_i(tag_i), .da_i(da_i),
        .plain_o(plain_o), .tag_valid_o(tag_valid_o), .busy_o(busy_o), .done_o(done_o),
        .core_init_o(core_init_o), .core_associate_data_o(core_associate_data_o),
        .core_finalisation_o(core_finalisation_o), .core_decrypt_o(core_decrypt_o),
        .core_data_o(core_data_o), .core_data_valid_o(core_data_valid_o),
        .core_end_initialisation_i(core_end_initialisation_i),
        .core_end_associate_i(core_end_associate_i),
        .core_out_valid_i(core_out_valid_i), .core_out_i(core_out_i),
        .core_tag_i(core_tag_i), .core_end_tag_i(core_end_tag_i)
    );

    always #5 clock_i = ~clock_i;

    // Core model: answers each request after `stall` wait cycles; FINAL uses its own delays.
    always_comb begin
        core_end_initialisation_i = core_init_o && (cnt == stall);
        core_end_associate_i      = core_associate_data_o && (cnt == stall);
        core_out_valid_i          = core_decrypt_o &&
                                    (core_finalisation_o ? (cnt == ov_dly) : (cnt == stall));
        core_end_tag_i            = core_finalisation_o && (cnt == tag_dly);
        core_out_i                = core_data_o ^ XMASK;
        core_tag_i                = MTAG;
    end

    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i) cnt <= 0;
        else if (!(core_init_o || core_associate_data_o || core_decrypt_o) ||
                 core_end_initialisation_i || core_end_associate_i ||
                 (core_out_valid_i && !core_finalisation_o)) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_plain(input string tag, input logic [W-1:0] exp);
        nchecks++;
        assert (plain_o === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, plain_o, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
        cyc++;
    endtask

    // cyc = 1 is the cycle start_i is high.
    task automatic start_msg();
        start_i = 1'b1;
        cyc = 1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int spur, output bit found);
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done_o) begin
                found = 1'b1;
                break;
            end
            start_i = (cyc == spur);
            step();
        end
        start_i = 1'b0;
    endtask

    task automatic wait_block(input logic [63:0] blk, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (core_decrypt_o && !core_finalisation_o && core_data_o == blk) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic count_done(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (done_o) n++;
            step();
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            cipher_i[64*k +: 64]  = 64'(k);
            exp_plain[64*k +: 64] = 64'(k) ^ XMASK;
        end
        tag_i = MTAG;
        #12;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_tag_valid", int'(tag_valid_o), 0);
        chk("rst_core_ctl", int'({core_init_o, core_associate_data_o, core_finalisation_o,
                                  core_decrypt_o, core_data_valid_o}), 0);
        chk("rst_core_data", int'(core_data_o != 64'd0), 0);
        chk_plain("rst_plain", '0);
        reset_i = 1'b0;
        @(posedge clock_i);
        #1;

        // Test 1: nominal
        start_msg();
        chk("t1_init", int'(core_init_o), 1);
        chk("t1_busy", int'(busy_o), 1);
        wait_done(-1, seen);
        chk("t1_done_seen", int'(seen), 1);
        chk("t1_latency", cyc, 27);
        step();
        chk("t1_tag_valid", int'(tag_valid_o), 1);
        chk("t1_idle", int'(busy_o), 0);
        chk_plain("t1_plain", exp_plain);
        count_done(5, extra);
        chk("t1_single_done", extra, 0);

        // Test 2: bad tag
        tag_i = MTAG ^ 128'd1;
        start_msg();
        chk("t2_tv_cleared", int'(tag_valid_o), 0);
        wait_done(-1, seen);
        chk("t2_done_seen", int'(seen), 1);
        step();
        chk("t2_tag_valid", int'(tag_valid_o), 0);
`ifdef ASCON_DEC_RELEASE_GATE_EN
        chk_plain("t2_plain", '0);
`else
        chk_plain("t2_plain", exp_plain);
`endif
        tag_i = MTAG;

        // Test 3: stalled core
        stall = 3;
        start_msg();
        wait_block(64'd1, seen);
        chk("t3_reach_blk1", int'(seen), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_data", int'(core_data_o == 64'd1 && core_decrypt_o && core_data_valid_o), 1);
        end
        wait_done(-1, seen);
        chk("t3_done_seen", int'(seen), 1);
        step();
        chk("t3_tag_valid", int'(tag_valid_o), 1);
        chk_plain("t3_plain", exp_plain);
        stall = 0;

        // Test 4: FINAL ordering (same cycle, block first, tag first)
        for (int m = 0; m < 3; m++) begin
            ov_dly  = (m == 2) ? 2 : 0;
            tag_dly = (m == 1) ? 2 : 0;
            start_msg();
            wait_done(-1, seen);
            chk("t4_done_seen", int'(seen), 1);
            step();
            chk("t4_tag_valid", int'(tag_valid_o), 1);
            chk_plain("t4_plain", exp_plain);
        end
        ov_dly  = 0;
        tag_dly = 0;

        // Test 5: asynchronous reset mid-DATA
        start_msg();
        wait_block(64'd10, seen);
        chk("t5_reach_idx10", int'(seen), 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("t5_busy", int'(busy_o), 0);
        chk_plain("t5_plain", '0);
        chk("t5_core_valid", int'(core_data_valid_o), 0);
        #2;
        reset_i = 1'b0;
        @(posedge clock_i);
        #1;
        start_msg();
        wait_done(-1, seen);
        chk("t5_done_seen", int'(seen), 1);
        chk("t5_latency", cyc, 27);
        step();
        chk("t5_tag_valid", int'(tag_valid_o), 1);
        chk_plain("t5_plain_after", exp_plain);

        // Test 6: spurious start in DATA, then back-to-back starts
        start_msg();
        wait_done(12, seen);
        chk("t6_done_seen", int'(seen), 1);
        chk("t6_latency", cyc, 27);
        step();
        count_done(40, extra);
        chk("t6_no_restart", extra, 0);
        chk("t6_idle", int'(busy_o), 0);
        start_msg();
        wait_done(-1, seen);
        chk("t6_b2b_first", int'(seen), 1);
        step();
        start_msg();
        chk("t6_b2b_busy", int'(busy_o), 1);
        wait_done(-1, seen);
        chk("t6_b2b_second", int'(seen), 1);
        chk("t6_b2b_latency", cyc, 27);
        step();
        chk("t6_tag_valid", int'(tag_valid_o), 1);
        chk_plain("t6_plain", exp_plain);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
